// File: rtl/types_def.sv
// Shared request types for the bank queues: request kind, address/data widths and the
// packed request carried through each queue.
package types_def;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef enum logic {
      ReqRead  = 1'b0,
      ReqWrite = 1'b1
   } r_type;

   typedef struct packed {
      r_type              req_type;
      logic [ADDR_W-1:0]  addr;
      logic [DATA_W-1:0]  data;
   } req_t;

   localparam int unsigned REQ_W = $bits(req_t);

endpackage

// File: rtl/bank_queue_mem.sv
// Entry storage for bank_queue: DEPTH x WIDTH register array, one write port and one
// registered read port with write-to-read bypass so a push into an empty queue shows next cycle.
module bank_queue_mem #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // raddr is the next head pointer, so rdata always holds the head entry of the next cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (we && (waddr == raddr)) begin
         rdata_q <= wdata;
      end else begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/bank_queue.sv
// Per-bank request FIFO with EMPTY/ACTIVE/FULL tracking and read/write counters.
// Define BANK_QUEUE_STATS_EN to add the max_occ and full_cycles statistics outputs.
module bank_queue
   import types_def::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 6,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  req_t             in_req,
   input  logic [IDX_W-1:0] in_index,
   output logic             grant,
   output logic             out_valid,
   input  logic             out_ready,
   output req_t             out_req,
   output logic [IDX_W-1:0] out_index,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
`ifdef BANK_QUEUE_STATS_EN
   output logic [CNT_W-1:0] max_occ,
   output logic [15:0]      full_cycles,
`endif
   output logic             empty
);

   typedef enum logic [1:0] {
      StEmpty,
      StActive,
      StFull
   } state_e;

   state_e           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
   logic             push, pop;

   assign grant     = (occ_q < CNT_W'(DEPTH));
   assign empty     = (state_q == StEmpty);
   assign out_valid = !empty;
   assign push      = in_valid && grant;
   assign pop       = out_valid && out_ready;
   assign rd_count  = rd_count_q;
   assign wr_count  = wr_count_q;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      occ_d      = occ_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (push) begin
         occ_d = occ_d + CNT_W'(1);
         if (in_req.req_type == ReqRead) rd_count_d = rd_count_d + CNT_W'(1);
         else                            wr_count_d = wr_count_d + CNT_W'(1);
      end
      if (pop) begin
         occ_d = occ_d - CNT_W'(1);
         if (out_req.req_type == ReqRead) rd_count_d = rd_count_d - CNT_W'(1);
         else                             wr_count_d = wr_count_d - CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty:  if (push) state_d = StActive;
         StActive: begin
            if (occ_d == CNT_W'(DEPTH)) state_d = StFull;
            else if (occ_d == '0)       state_d = StEmpty;
         end
         StFull:   if (pop) state_d = StActive;
         default:  state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StEmpty;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   bank_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W + IDX_W)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (push && rst),
      .waddr (wr_ptr_q),
      .wdata ({in_req, in_index}),
      .raddr (rd_ptr_d),
      .rdata ({out_req, out_index})
   );

`ifdef BANK_QUEUE_STATS_EN
   logic [CNT_W-1:0] max_occ_q;
   logic [15:0]      full_cycles_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         max_occ_q     <= '0;
         full_cycles_q <= '0;
      end else begin
         if (occ_d > max_occ_q) max_occ_q <= occ_d;
         if ((state_q == StFull) && (full_cycles_q != 16'hFFFF)) begin
            full_cycles_q <= full_cycles_q + 16'd1;
         end
      end
   end

   assign max_occ     = max_occ_q;
   assign full_cycles = full_cycles_q;
`endif

endmodule
